sd_sector_arbiter: RTL and testbench

- Shares the single SD-card sector engine between up to four sector requesters: four floppy drive emulators, or drives plus a hard-disk emulator.
- Each requester raises a level read/write request carrying its own image-relative sector number.
- The arbiter grants round-robin and translates the sector to an absolute card LBA through a per-source image base.
- It runs the start/busy/done handshake with the SD engine and steers the 512-byte sector byte stream to and from the granted requester.

---
 rtl/sdarb_pkg.sv | 17 +
 rtl/sd_sector_arbiter_rr_pick.sv | 30 +++
 rtl/sd_sector_arbiter.sv | 154 +++++++++++++++
 tb/tb_sd_sector_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdarb_pkg.sv
// Shared types and constants for the SD sector arbiter.
// FSM encoding, default image size and sector byte count.
package sdarb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_t;

  localparam int IMG_SECTORS_DEF = 1600;
  localparam int SECTOR_BYTES = 512;
  localparam int TMO_W = 25;

endpackage

// File: rtl/sd_sector_arbiter_rr_pick.sv
// Round-robin first-one search over NSRC pending bits,
// starting at ptr and wrapping from NSRC-1 back to 0.
module rr_pick #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] pending,
  input  logic [1:0]      ptr,
  output logic [1:0]      idx,
  output logic            vld
);

  logic [3:0] p4;
  logic [1:0] j;

  assign p4 = 4'(pending);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    j = '0;
    for (int k = 0; k < NSRC; k++) begin
      j = 2'((int'(ptr) + k) % NSRC);
      if (!vld && p4[j]) begin
        vld = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares one SD sector engine among NSRC requesters, round-robin.
// Optional watchdog: define SDARB_TIMEOUT_EN.
module sd_sector_arbiter
  import sdarb_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int IMG_SECTORS = IMG_SECTORS_DEF,
  parameter int BASE_LBA = 0,
  parameter int TIMEOUT_CYC = 25000000
) (
  input  logic                pin_25mhz_ck,
  input  logic                ppu_vm_init_n,
  input  logic [NSRC-1:0]     req_rd,
  input  logic [NSRC-1:0]     req_wr,
  input  logic [32*NSRC-1:0]  req_sector,
  output logic [NSRC-1:0]     src_busy,
  output logic [NSRC-1:0]     src_done,
  output logic [NSRC-1:0]     src_err,
  output logic [1:0]          grant_idx,
  output logic                grant_vld,
  output logic                sd_rstart,
  output logic                sd_wstart,
  output logic [31:0]         sd_sector,
  input  logic                sd_busy,
  input  logic                sd_done,
  input  logic                sd_outen,
  input  logic [8:0]          sd_outaddr,
  input  logic [7:0]          sd_outbyte,
  output logic [7:0]          sd_inbyte,
  output logic [NSRC-1:0]     src_outen,
  output logic [8:0]          src_outaddr,
  output logic [7:0]          src_outbyte,
  input  logic [8*NSRC-1:0]   src_inbyte
);

  localparam int ADDR_W = $clog2(SECTOR_BYTES);

  state_t state, nxt;
  logic [1:0] gidx, ptr, pick_idx;
  logic pick_vld, op_wr, err_q;
  logic take, load_lba, set_err, tmo_hit;
  logic [31:0] sec_q, lba_q;
  logic [NSRC-1:0] pending, gmask;
  logic [3:0] wr4;

  assign pending = req_rd | req_wr;
  assign wr4 = 4'(req_wr);

  rr_pick #(.NSRC(NSRC)) u_pick (
    .pending (pending),
    .ptr     (ptr),
    .idx     (pick_idx),
    .vld     (pick_vld)
  );

`ifdef SDARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic in_op;

  assign in_op = (state == S_ISSUE) || (state == S_WAIT);
  assign tmo_hit = in_op && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge pin_25mhz_ck or negedge ppu_vm_init_n) begin
    if (!ppu_vm_init_n)
      tmo_cnt <= '0;
    else if (in_op && !tmo_hit)
      tmo_cnt <= tmo_cnt + 1'b1;
    else
      tmo_cnt <= '0;
  end
`else
  localparam int unused_tmo = TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    nxt = state;
    take = 1'b0;
    load_lba = 1'b0;
    set_err = 1'b0;
    unique case (state)
      S_IDLE:
        if (pick_vld) begin
          take = 1'b1;
          nxt = S_CHECK;
        end
      S_CHECK:
        if (sec_q >= 32'(IMG_SECTORS)) begin
          set_err = 1'b1;
          nxt = S_FINISH;
        end else begin
          load_lba = 1'b1;
          nxt = S_ISSUE;
        end
      S_ISSUE:
        if (sd_done) nxt = S_FINISH;
        else if (sd_busy) nxt = S_WAIT;
      // busy falling without a done pulse still ends the op
      S_WAIT:
        if (sd_done || !sd_busy) nxt = S_FINISH;
      S_FINISH:
        nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
    if (tmo_hit) begin
      set_err = 1'b1;
      nxt = S_FINISH;
    end
  end

  always_ff @(posedge pin_25mhz_ck or negedge ppu_vm_init_n) begin
    if (!ppu_vm_init_n) begin
      state <= S_IDLE;
      gidx  <= '0;
      ptr   <= '0;
      op_wr <= 1'b0;
      err_q <= 1'b0;
      sec_q <= '0;
      lba_q <= '0;
    end else begin
      state <= nxt;
      if (take) begin
        gidx  <= pick_idx;
        op_wr <= wr4[pick_idx];
        sec_q <= req_sector[{pick_idx, 5'b0} +: 32];
        err_q <= 1'b0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
      if (load_lba)
        lba_q <= 32'(BASE_LBA) + 32'(IMG_SECTORS) * {30'b0, gidx} + sec_q;
      if (state == S_FINISH)
        ptr <= (gidx == 2'(NSRC - 1)) ? 2'd0 : gidx + 2'd1;
    end
  end

  assign gmask = {{(NSRC-1){1'b0}}, 1'b1} << gidx;

  assign grant_vld = (state != S_IDLE);
  assign grant_idx = gidx;
  assign src_busy  = grant_vld ? gmask : '0;
  assign src_done  = (state == S_FINISH) ? gmask : '0;
  assign src_err   = (state == S_FINISH && err_q) ? gmask : '0;
  assign sd_rstart = (state == S_ISSUE) && !op_wr;
  assign sd_wstart = (state == S_ISSUE) && op_wr;
  assign sd_sector = lba_q;

  assign src_outen = (grant_vld && state == S_WAIT && sd_outen) ? gmask : '0;
  assign sd_inbyte = grant_vld ? src_inbyte[{gidx, 3'b0} +: 8] : 8'h00;
  assign src_outaddr = sd_outaddr[ADDR_W-1:0];
  assign src_outbyte = sd_outbyte;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter: vector table plus
// round-robin, byte steering, reset and optional watchdog sequences.
module tb_sd_sector_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_rd, req_wr;
  logic [127:0] req_sector;
  logic [3:0] src_busy, src_done, src_err, src_outen;
  logic [1:0] grant_idx;
  logic grant_vld, sd_rstart, sd_wstart;
  logic [31:0] sd_sector;
  logic sd_busy, sd_done, sd_outen;
  logic [8:0] sd_outaddr, src_outaddr;
  logic [7:0] sd_outbyte, sd_inbyte, src_outbyte;
  logic [31:0] src_inbyte;

  int nchk = 0;
  int nerr = 0;

  always #20 clk = ~clk;

  sd_sector_arbiter #(
    .NSRC(4),
    .IMG_SECTORS(1600),
    .BASE_LBA(0),
`ifdef SDARB_TIMEOUT_EN
    .TIMEOUT_CYC(100)
`else
    .TIMEOUT_CYC(25000000)
`endif
  ) dut (
    .pin_25mhz_ck  (clk),
    .ppu_vm_init_n (rst_n),
    .req_rd        (req_rd),
    .req_wr        (req_wr),
    .req_sector    (req_sector),
    .src_busy      (src_busy),
    .src_done      (src_done),
    .src_err       (src_err),
    .grant_idx     (grant_idx),
    .grant_vld     (grant_vld),
    .sd_rstart     (sd_rstart),
    .sd_wstart     (sd_wstart),
    .sd_sector     (sd_sector),
    .sd_busy       (sd_busy),
    .sd_done       (sd_done),
    .sd_outen      (sd_outen),
    .sd_outaddr    (sd_outaddr),
    .sd_outbyte    (sd_outbyte),
    .sd_inbyte     (sd_inbyte),
    .src_outen     (src_outen),
    .src_outaddr   (src_outaddr),
    .src_outbyte   (src_outbyte),
    .src_inbyte    (src_inbyte)
  );

  typedef struct {
    int          src;
    logic        rd;
    logic        wr;
    logic [31:0] sec;
    logic [31:0] lba;
    logic        err;
  } vec_t;

  vec_t vt[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] m(input int s);
    return 4'(1 << s);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    req_sector[32*v.src +: 32] = v.sec;
    req_rd[v.src] = v.rd;
    req_wr[v.src] = v.wr;
    tick();
    chk("grant_vld", 32'(grant_vld), 32'd1);
    chk("grant_idx", 32'(grant_idx), 32'(v.src));
    chk("busy_check", 32'(src_busy), 32'(m(v.src)));
    tick();
    if (v.err) begin
      chk("err_done", 32'(src_done), 32'(m(v.src)));
      chk("err_err", 32'(src_err), 32'(m(v.src)));
      chk("err_nostart", 32'({sd_rstart, sd_wstart}), 32'd0);
    end else begin
      chk("lba", sd_sector, v.lba);
      chk("rstart", 32'(sd_rstart), 32'(!v.wr));
      chk("wstart", 32'(sd_wstart), 32'(v.wr));
      tick();
      chk("start_hold", 32'(sd_rstart | sd_wstart), 32'd1);
      sd_busy = 1'b1;
      tick();
      chk("start_drop", 32'({sd_rstart, sd_wstart}), 32'd0);
      chk("busy_wait", 32'(src_busy), 32'(m(v.src)));
      tick();
      tick();
      sd_busy = 1'b0;
      sd_done = 1'b1;
      tick();
      sd_done = 1'b0;
      chk("done", 32'(src_done), 32'(m(v.src)));
      chk("noerr", 32'(src_err), 32'd0);
      chk("busy_fin", 32'(src_busy), 32'(m(v.src)));
    end
    req_rd = '0;
    req_wr = '0;
    tick();
    chk("idle_busy", 32'(src_busy), 32'd0);
    chk("idle_vld", 32'(grant_vld), 32'd0);
    chk("idle_done", 32'(src_done), 32'd0);
  endtask

  initial begin
    int c3, cother, abad, cnt;

    vt[0] = '{2, 1'b1, 1'b0, 32'd5,          32'd3205, 1'b0};
    vt[1] = '{1, 1'b1, 1'b1, 32'd0,          32'd1600, 1'b0};
    vt[2] = '{0, 1'b1, 1'b0, 32'd1600,       32'd0,    1'b1};
    vt[3] = '{3, 1'b1, 1'b0, 32'd1599,       32'd6399, 1'b0};
    vt[4] = '{0, 1'b0, 1'b1, 32'd7,          32'd7,    1'b0};
    vt[5] = '{3, 1'b0, 1'b1, 32'hFFFF_FFFF,  32'd0,    1'b1};

    rst_n = 1'b0;
    req_rd = '0;
    req_wr = '0;
    req_sector = '0;
    sd_busy = 1'b0;
    sd_done = 1'b0;
    sd_outen = 1'b0;
    sd_outaddr = '0;
    sd_outbyte = '0;
    src_inbyte = '0;
    #5;
    chk("rst_vld", 32'(grant_vld), 32'd0);
    chk("rst_busy", 32'(src_busy), 32'd0);
    chk("rst_sector", sd_sector, 32'd0);
    chk("rst_start", 32'({sd_rstart, sd_wstart}), 32'd0);
    do_reset();

    foreach (vt[i]) run_vec(vt[i]);

    // all four requesters held: round robin from pointer 0
    do_reset();
    chk("rr_rst_idx", 32'(grant_idx), 32'd0);
    req_sector = '0;
    req_rd = 4'hF;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 20 && !grant_vld; c++) tick();
      chk("rr_grant", 32'(grant_idx), 32'(g % 4));
      for (int c = 0; c < 20 && !sd_rstart; c++) tick();
      chk("rr_rstart", 32'(sd_rstart), 32'd1);
      sd_busy = 1'b1;
      repeat (10) tick();
      sd_busy = 1'b0;
      sd_done = 1'b1;
      tick();
      sd_done = 1'b0;
      chk("rr_done", 32'(src_done), 32'(m(g % 4)));
      tick();
      if (g == 4) req_rd = '0;
    end
    tick();

    // source 3 read with a full sector of byte strobes
    req_rd[3] = 1'b1;
    tick();
    tick();
    sd_busy = 1'b1;
    tick();
    req_rd = '0;
    c3 = 0;
    cother = 0;
    abad = 0;
    for (int n = 0; n < 512; n++) begin
      sd_outen = 1'b1;
      sd_outaddr = 9'(n);
      sd_outbyte = 8'(n * 3);
      #5;
      if (src_outen[3]) c3++;
      if (src_outen[2:0] != 3'b0) cother++;
      if (src_outaddr != 9'(n) || src_outbyte != 8'(n * 3)) abad++;
      sd_outen = 1'b0;
      #5;
      if (src_outen != 4'b0) cother++;
      tick();
    end
    chk("outen_src3", 32'(c3), 32'd512);
    chk("outen_other", 32'(cother), 32'd0);
    chk("outaddr_bcast", 32'(abad), 32'd0);
    sd_busy = 1'b0;
    sd_done = 1'b1;
    tick();
    sd_done = 1'b0;
    chk("rd3_done", 32'(src_done), 32'h8);
    tick();

    // source 3 write: its byte lane drives the card
    src_inbyte = 32'hA5_3C_77_11;
    #1;
    chk("inbyte_idle", 32'(sd_inbyte), 32'd0);
    req_wr[3] = 1'b1;
    tick();
    chk("wr3_grant", 32'(grant_idx), 32'd3);
    chk("inbyte_src3", 32'(sd_inbyte), 32'hA5);
    tick();
    chk("wr3_wstart", 32'(sd_wstart), 32'd1);
    sd_busy = 1'b1;
    tick();
    sd_busy = 1'b0;
    sd_done = 1'b1;
    tick();
    sd_done = 1'b0;
    req_wr = '0;
    tick();

    // reset asserted while waiting on the engine
    req_sector[64 +: 32] = 32'd5;
    req_rd[2] = 1'b1;
    tick();
    tick();
    sd_busy = 1'b1;
    tick();
    sd_outen = 1'b1;
    #5;
    chk("wait_outen", 32'(src_outen), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(grant_vld), 32'd0);
    chk("mrst_busy", 32'(src_busy), 32'd0);
    chk("mrst_start", 32'({sd_rstart, sd_wstart}), 32'd0);
    chk("mrst_outen", 32'(src_outen), 32'd0);
    chk("mrst_inbyte", 32'(sd_inbyte), 32'd0);
    chk("mrst_sector", sd_sector, 32'd0);
    req_rd = '0;
    sd_busy = 1'b0;
    sd_outen = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_vld", 32'(grant_vld), 32'd0);

`ifdef SDARB_TIMEOUT_EN
    req_sector = '0;
    req_rd[0] = 1'b1;
    tick();
    tick();
    sd_busy = 1'b1;
    req_rd = '0;
    cnt = 0;
    for (int c = 0; c < 300 && !src_err[0]; c++) begin
      tick();
      cnt++;
    end
    chk("tmo_cycles", 32'(cnt), 32'd100);
    chk("tmo_done", 32'(src_done), 32'h1);
    chk("tmo_start", 32'({sd_rstart, sd_wstart}), 32'd0);
    sd_busy = 1'b0;
    tick();
`else
    cnt = 0;
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
